// File: rtl/mmcm_lock_sequencer_pkg.sv
// Shared state encoding and field widths for the MMCM lock sequencer.
package mmcm_seq_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    READY      = 3'd3,
    FAULT      = 3'd4
  } seq_state_e;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mmcm_lock_sequencer_if.sv
// Signal bundle between the lock sequencer, the MMCM and downstream logic.
// lock_loss_count exists only when MMCM_LOCK_LOSS_CNT_EN is defined.
interface mmcm_lock_sequencer_if;
  import mmcm_seq_pkg::*;

  logic               locked_in;
  logic               mmcm_rst;
  logic               ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_count;
`ifdef MMCM_LOCK_LOSS_CNT_EN
  logic [LOSS_W-1:0]  lock_loss_count;
`endif

  modport master (
`ifdef MMCM_LOCK_LOSS_CNT_EN
    output lock_loss_count,
`endif
    input  locked_in,
    output mmcm_rst,
    output ready,
    output fault,
    output retry_count
  );

  modport slave (
`ifdef MMCM_LOCK_LOSS_CNT_EN
    input  lock_loss_count,
`endif
    output locked_in,
    input  mmcm_rst,
    input  ready,
    input  fault,
    input  retry_count
  );

endinterface

// File: rtl/mmcm_lock_sequencer_bit_sync.sv
// N-stage single-bit synchronizer with asynchronous active-low clear,
// for bringing asynchronous status bits into the clk domain.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/mmcm_lock_sequencer.sv
// Reset/lock supervisor for an MMCME2_ADV: pulses RST, retries, flags fault, qualifies ready.
// Optional lock-loss counter is enabled by defining MMCM_LOCK_LOSS_CNT_EN.
module mmcm_lock_sequencer
  import mmcm_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mmcm_lock_sequencer_if.master bus
);

  localparam int CNT_MAX = max3(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0]   HOLD_LD   = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HOLD_RST  = CNT_W'(RST_HOLD_CYCLES);
  localparam logic [CNT_W-1:0]   TMO_LD    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STB_LD    = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  logic               w_lk;
  seq_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               w_cnt_zero;
  logic [RETRY_W-1:0] r_retry_count, w_retry_nxt;
  logic               r_mmcm_rst, w_mmcm_rst_nxt;
  logic               r_ready, w_ready_nxt;
  logic               r_fault, w_fault_nxt;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.locked_in),
    .o_q   (w_lk)
  );

  assign w_cnt_zero = (r_cnt == '0);

  // NOTE: every signal driven here gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry_count;
    case (r_state)
      RESET_HOLD: if (w_cnt_zero) w_state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        // Lock is tested first so it wins over a coincident timeout.
        if (w_lk) begin
          w_state_nxt = STABLE;
        end else if (w_cnt_zero) begin
          if (r_retry_count == RETRY_MAX) begin
            w_state_nxt = FAULT;
          end else begin
            w_state_nxt = RESET_HOLD;
            w_retry_nxt = r_retry_count + RETRY_W'(1);
          end
        end
      end
      STABLE: begin
        if (!w_lk) begin
          w_state_nxt = WAIT_LOCK;
        end else if (w_cnt_zero) begin
          w_state_nxt = READY;
          w_retry_nxt = '0;
        end
      end
      READY:   if (!w_lk) w_state_nxt = RESET_HOLD;
      FAULT:   w_state_nxt = FAULT;
      default: w_state_nxt = FAULT;
    endcase

    w_mmcm_rst_nxt = (w_state_nxt == RESET_HOLD) || (w_state_nxt == FAULT);
    w_ready_nxt    = (w_state_nxt == READY);
    w_fault_nxt    = (w_state_nxt == FAULT);
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        RESET_HOLD: w_cnt_nxt = HOLD_LD;
        WAIT_LOCK:  w_cnt_nxt = TMO_LD;
        STABLE:     w_cnt_nxt = STB_LD;
        default:    w_cnt_nxt = '0;
      endcase
    end else if (!w_cnt_zero) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RESET_HOLD;
      // NOTE: one extra count here because the release edge itself is not an entry edge; the first pulse is still RST_HOLD_CYCLES long.
      r_cnt         <= HOLD_RST;
      r_retry_count <= '0;
      r_mmcm_rst    <= 1'b1;
      r_ready       <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_retry_count <= w_retry_nxt;
      r_mmcm_rst    <= w_mmcm_rst_nxt;
      r_ready       <= w_ready_nxt;
      r_fault       <= w_fault_nxt;
    end
  end

  assign bus.mmcm_rst    = r_mmcm_rst;
  assign bus.ready       = r_ready;
  assign bus.fault       = r_fault;
  assign bus.retry_count = r_retry_count;

`ifdef MMCM_LOCK_LOSS_CNT_EN
  logic [LOSS_W-1:0] r_lock_loss_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_loss_count <= '0;
    end else if ((r_state == READY) && !w_lk && (r_lock_loss_count != '1)) begin
      r_lock_loss_count <= r_lock_loss_count + LOSS_W'(1);
    end
  end

  assign bus.lock_loss_count = r_lock_loss_count;
`endif

endmodule

// File: tb/tb_mmcm_lock_sequencer.sv
// Directed bench for mmcm_lock_sequencer at 8/64/16/3/2; lock-loss checks
// are compiled in only when MMCM_LOCK_LOSS_CNT_EN is defined.
module tb_mmcm_lock_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mmcm_lock_sequencer_if bus ();

  mmcm_lock_sequencer #(
    .RST_HOLD_CYCLES     (8),
    .LOCK_TIMEOUT_CYCLES (64),
    .LOCK_STABLE_CYCLES  (16),
    .MAX_RETRIES         (3),
    .SYNC_STAGES         (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       rst_n;
    logic       locked_in;
    int         cycles;
    logic       mmcm_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry;
    logic [7:0] loss;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge before sampling.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic m, input logic r,
                            input logic f, input logic [3:0] rc);
    check({tag, "_mmcm_rst"},    bus.mmcm_rst,    m);
    check({tag, "_ready"},       bus.ready,       r);
    check({tag, "_fault"},       bus.fault,       f);
    check({tag, "_retry_count"}, bus.retry_count, rc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rst_high;
    int ready_early;
    int timeouts;

    // Rows: rst_n, locked_in, cycles to advance, then expected mmcm_rst/ready/fault/retry/loss.
    // Edge numbers in comments count from the first edge with rst_n high.
    vecs[0]  = '{1'b0, 1'b0,  3, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0}; // reset values
    vecs[1]  = '{1'b1, 1'b0,  8, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0}; // e8: still holding
    vecs[2]  = '{1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}; // e9: RST falls
    vecs[3]  = '{1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}; // e19
    vecs[4]  = '{1'b1, 1'b1, 18, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}; // e37: 18 edges after rise
    vecs[5]  = '{1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0}; // e38: ready after 19
    vecs[6]  = '{1'b1, 1'b1, 20, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0}; // stays ready
    vecs[7]  = '{1'b0, 1'b0,  2, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0}; // reset from READY
    vecs[8]  = '{1'b1, 1'b0,  8, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0}; // e8
    vecs[9]  = '{1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}; // e9
    vecs[10] = '{1'b1, 1'b0, 63, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}; // e72: last wait cycle
    vecs[11] = '{1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0}; // e73: retry 1
    vecs[12] = '{1'b1, 1'b0,  7, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0}; // e80
    vecs[13] = '{1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b0, 4'd1, 8'd0}; // e81
    vecs[14] = '{1'b1, 1'b0, 63, 1'b0, 1'b0, 1'b0, 4'd1, 8'd0}; // e144
    vecs[15] = '{1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b0, 4'd2, 8'd0}; // e145: retry 2
    vecs[16] = '{1'b1, 1'b0,  8, 1'b0, 1'b0, 1'b0, 4'd2, 8'd0}; // e153
    vecs[17] = '{1'b1, 1'b0, 64, 1'b1, 1'b0, 1'b0, 4'd3, 8'd0}; // e217: retry 3
    vecs[18] = '{1'b1, 1'b0,  8, 1'b0, 1'b0, 1'b0, 4'd3, 8'd0}; // e225
    vecs[19] = '{1'b1, 1'b0, 63, 1'b0, 1'b0, 1'b0, 4'd3, 8'd0}; // e288
    vecs[20] = '{1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b1, 4'd3, 8'd0}; // e289: FAULT
    vecs[21] = '{1'b1, 1'b1, 50, 1'b1, 1'b0, 1'b1, 4'd3, 8'd0}; // FAULT ignores lock

    rst_n         = 1'b1;
    bus.locked_in = 1'b0;
    #2;

    for (int i = 0; i < 22; i++) begin
      rst_n         = vecs[i].rst_n;
      bus.locked_in = vecs[i].locked_in;
      step(vecs[i].cycles);
      check_outs($sformatf("vec%0d", i), vecs[i].mmcm_rst, vecs[i].ready,
                 vecs[i].fault, vecs[i].retry);
`ifdef MMCM_LOCK_LOSS_CNT_EN
      check($sformatf("vec%0d_lock_loss_count", i), bus.lock_loss_count, vecs[i].loss);
`endif
    end

    // Asynchronous reset from FAULT, sampled before any clock edge.
    rst_n = 1'b0;
    #2;
    check_outs("rst_in_fault", 1'b1, 1'b0, 1'b0, 4'd0);

    // Asynchronous reset from WAIT_LOCK with two retries used.
    bus.locked_in = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(160);
    check_outs("wait_retry2", 1'b0, 1'b0, 1'b0, 4'd2);
    rst_n = 1'b0;
    #2;
    check_outs("rst_in_wait", 1'b1, 1'b0, 1'b0, 4'd0);

    // Two-cycle glitch ten cycles into STABLE.
    step(2);
    rst_n = 1'b1;
    step(9);
    check("glitch_rst_fall", bus.mmcm_rst, 1'b0);
    bus.locked_in = 1'b1;
    step(13);
    check("glitch_in_stable", bus.ready, 1'b0);
    bus.locked_in = 1'b0;
    step(2);
    bus.locked_in = 1'b1;
    rst_high    = 0;
    ready_early = 0;
    for (int k = 0; k < 18; k++) begin
      step(1);
      if (bus.mmcm_rst) rst_high++;
      if (bus.ready) ready_early++;
    end
    check("glitch_no_rst_pulse", rst_high, 0);
    check("glitch_no_early_ready", ready_early, 0);
    step(1);
    check_outs("glitch_ready_19", 1'b0, 1'b1, 1'b0, 4'd0);

    // Lock loss while READY, then relock.
    step(5);
    bus.locked_in = 1'b0;
    step(2);
    check_outs("loss_plus2", 1'b0, 1'b1, 1'b0, 4'd0);
    step(1);
    check_outs("loss_plus3", 1'b1, 1'b0, 1'b0, 4'd0);
`ifdef MMCM_LOCK_LOSS_CNT_EN
    check("loss_count_1", bus.lock_loss_count, 8'd1);
`endif
    bus.locked_in = 1'b1;
    step(7);
    check("relock_hold", bus.mmcm_rst, 1'b1);
    step(1);
    check("relock_rst_fall", bus.mmcm_rst, 1'b0);
    step(16);
    check("relock_not_yet", bus.ready, 1'b0);
    step(1);
    check("relock_ready", bus.ready, 1'b1);

`ifdef MMCM_LOCK_LOSS_CNT_EN
    // Drive the lock-loss counter to saturation and one step past it.
    timeouts = 0;
    for (int k = 0; k < 255; k++) begin
      bus.locked_in = 1'b0;
      step(3);
      bus.locked_in = 1'b1;
      for (int w = 0; w < 40 && bus.ready !== 1'b1; w++) step(1);
      if (bus.ready !== 1'b1) timeouts++;
      if (k == 253) check("loss_count_255", bus.lock_loss_count, 8'd255);
    end
    check("sat_relock_timeouts", timeouts, 0);
    check("loss_count_saturated", bus.lock_loss_count, 8'd255);
`else
    timeouts = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
